mat_seq_ctrl: RTL and testbench

- Parametrised operand sequencer for the systolic matrix-multiply datapath (Frodo A·S, S·A, S·B, B·S).
- Generates read addresses for the HASH, single-port and dual-port BRAMs and steers read data onto the left and right systolic inputs.
- Controls the ping-pong transposer and the systolic state and mode lines.
- Sequences LOAD, DRAIN and SAVE for every result block, with a start/done handshake and a stall input.

---
 rtl/mat_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mat_seq_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_seq_ctrl.sv
// Operand sequencer for the systolic matrix-multiply datapath: BRAM address generation,
// operand steering, LOAD/DRAIN/SAVE sequencing. Define MAT_SEQ_PERF_EN to build the perf counters.
`timescale 1ns/1ps
module mat_seq_ctrl #(
    parameter int unsigned TILE      = 4,
    parameter int unsigned N_LINES   = 336,
    parameter int unsigned N_BLK     = 2,
    parameter int unsigned DRAIN_CYC = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 32,
    localparam int unsigned BEAT_W   = (TILE > 1) ? $clog2(TILE) : 1,
    localparam int unsigned BLK_W    = (N_BLK > 1) ? $clog2(N_BLK) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [ADDR_W-1:0] cfg_l_base,
    input  logic [ADDR_W-1:0] cfg_l_line_step,
    input  logic [ADDR_W-1:0] cfg_l_beat_step,
    input  logic [ADDR_W-1:0] cfg_r_base,
    input  logic [ADDR_W-1:0] cfg_r_blk_step,
    input  logic [ADDR_W-1:0] cfg_r_line_step,
    input  logic [ADDR_W-1:0] cfg_r_beat_step,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] bram_data_hash,
    input  logic [DATA_W-1:0] bram_data_sp,
    input  logic [DATA_W-1:0] bram_data_dp,
    output logic [ADDR_W-1:0] addr_hash,
    output logic [ADDR_W-1:0] addr_sp,
    output logic [ADDR_W-1:0] addr_dp,
    output logic              rd_en,
    output logic [DATA_W-1:0] data_left,
    output logic [DATA_W-1:0] data_right,
    output logic              data_vld,
    output logic              transposition_select,
    output logic              systolic_state,
    output logic              systolic_mode,
    output logic              res_we,
    output logic [BEAT_W-1:0] res_row,
    output logic [BLK_W-1:0]  res_blk,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc
);
    localparam int unsigned LINE_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;
    localparam int unsigned DRN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_SAVE, S_DONE} state_t;
    typedef enum logic [2:0] {M_NONE = 3'd0, M_AS = 3'd1, M_SA = 3'd2, M_SB = 3'd3, M_BS = 3'd4} mode_t;

    state_t              r_state, w_next;
    mode_t               r_mode;
    logic [BEAT_W-1:0]   r_beat;
    logic [LINE_W-1:0]   r_line;
    logic [BLK_W-1:0]    r_blk;
    logic [DRN_W-1:0]    r_drain;
    logic                r_tsel, r_sys_mode;
    logic [ADDR_W-1:0]   r_l_base, r_l_line, r_l_beat, r_r_base, r_r_blk, r_r_line, r_r_beat;
    logic                r_vld_pipe  [RD_LAT];
    mode_t               r_mode_pipe [RD_LAT];
    logic                w_start_ok, w_last_beat, w_last_line, w_drain_end, w_last_blk, w_busy;
    logic [ADDR_W-1:0]   w_l, w_r;

    assign w_start_ok  = start && (mode != 3'd0) && (mode <= 3'd4) && (r_state == S_IDLE);
    assign w_last_beat = (r_beat == BEAT_W'(TILE - 1));
    assign w_last_line = (r_line == LINE_W'(N_LINES - 1));
    assign w_drain_end = (r_drain == DRN_W'(DRAIN_CYC - 1));
    assign w_last_blk  = (r_blk == BLK_W'(N_BLK - 1));
    assign w_busy      = (r_state != S_IDLE);

    always_comb begin
        w_next = r_state;
        if (mem_rdy) begin
            case (r_state)
                S_IDLE:  if (w_start_ok) w_next = S_LOAD;
                S_LOAD:  if (w_last_beat && w_last_line) w_next = S_DRAIN;
                S_DRAIN: if (w_drain_end) w_next = S_SAVE;
                S_SAVE:  if (w_last_beat) w_next = w_last_blk ? S_DONE : S_LOAD;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // The beat counter doubles as the SAVE row index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= M_NONE;  r_beat <= '0;  r_line <= '0;  r_blk <= '0;  r_drain <= '0;
            r_tsel <= 1'b1;    r_sys_mode <= 1'b0;
            r_l_base <= '0; r_l_line <= '0; r_l_beat <= '0;
            r_r_base <= '0; r_r_blk <= '0; r_r_line <= '0; r_r_beat <= '0;
        end else if (mem_rdy) begin
            case (r_state)
                S_IDLE: if (w_start_ok) begin
                    r_mode     <= mode_t'(mode);
                    r_sys_mode <= (mode == 3'd1) || (mode == 3'd3);
                    r_beat <= '0;  r_line <= '0;  r_blk <= '0;  r_drain <= '0;  r_tsel <= 1'b1;
                    r_l_base <= cfg_l_base;  r_l_line <= cfg_l_line_step;  r_l_beat <= cfg_l_beat_step;
                    r_r_base <= cfg_r_base;  r_r_blk <= cfg_r_blk_step;
                    r_r_line <= cfg_r_line_step;  r_r_beat <= cfg_r_beat_step;
                end
                S_LOAD: begin
                    if (r_beat == '0) r_tsel <= ~r_tsel;
                    if (w_last_beat) begin
                        r_beat <= '0;
                        r_line <= w_last_line ? '0 : r_line + 1'b1;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                S_DRAIN: r_drain <= w_drain_end ? '0 : r_drain + 1'b1;
                S_SAVE: begin
                    r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                    if (w_last_beat) begin
                        r_line <= '0;
                        if (!w_last_blk) r_blk <= r_blk + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_l = r_l_base + ADDR_W'(r_line) * r_l_line + ADDR_W'(r_beat) * r_l_beat;
    assign w_r = r_r_base + ADDR_W'(r_blk) * r_r_blk + ADDR_W'(r_line) * r_r_line
               + ADDR_W'(r_beat) * r_r_beat;

    always_comb begin
        addr_hash = '0;
        addr_sp   = '0;
        addr_dp   = '0;
        if (r_state == S_LOAD) begin
            case (r_mode)
                M_AS:    begin addr_hash = w_l; addr_sp   = w_r; end
                M_SA:    begin addr_sp   = w_l; addr_hash = w_r; end
                M_SB:    begin addr_sp   = w_l; addr_dp   = w_r; end
                M_BS:    begin addr_dp   = w_l; addr_sp   = w_r; end
                default: ;
            endcase
        end
    end

    assign rd_en = (r_state == S_LOAD) && mem_rdy;

    // The read pipeline is never frozen: stalled beats simply show up as data_vld=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_vld_pipe[i]  <= 1'b0;
                r_mode_pipe[i] <= M_NONE;
            end
        end else begin
            r_vld_pipe[0]  <= rd_en;
            r_mode_pipe[0] <= r_mode;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_mode_pipe[i] <= r_mode_pipe[i-1];
            end
        end
    end

    assign data_vld = r_vld_pipe[RD_LAT-1];

    always_comb begin
        data_left  = '0;
        data_right = '0;
        if (data_vld) begin
            case (r_mode_pipe[RD_LAT-1])
                M_AS:    begin data_left = bram_data_hash; data_right = bram_data_sp;   end
                M_SA:    begin data_left = bram_data_sp;   data_right = bram_data_hash; end
                M_SB:    begin data_left = bram_data_sp;   data_right = bram_data_dp;   end
                M_BS:    begin data_left = bram_data_dp;   data_right = bram_data_sp;   end
                default: ;
            endcase
        end
    end

    assign transposition_select = r_tsel;
    assign systolic_state       = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign systolic_mode        = r_sys_mode;
    assign res_we               = (r_state == S_SAVE) && mem_rdy;
    assign res_row              = (r_state == S_SAVE) ? r_beat : '0;
    assign res_blk              = r_blk;
    assign busy                 = w_busy;
    assign done                 = (r_state == S_DONE);

`ifdef MAT_SEQ_PERF_EN
    logic [31:0] r_perf_busy, r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst || (w_start_ok && mem_rdy)) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_busy && (r_perf_busy != '1))               r_perf_busy  <= r_perf_busy + 1'b1;
            if (w_busy && !mem_rdy && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_busy_cyc  = r_perf_busy;
    assign perf_stall_cyc = r_perf_stall;
`else
    assign perf_busy_cyc  = '0;
    assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_mat_seq_ctrl.sv
// Directed bench for mat_seq_ctrl: one instance with RD_LAT=1, a second with RD_LAT=3 on shared inputs.
`timescale 1ns/1ps
module tb_mat_seq_ctrl;
    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst, start, mem_rdy;
    logic [2:0]    mode;
    logic [AW-1:0] l_base, l_line, l_beat, r_base, r_blk, r_line, r_beat;
    logic [DW-1:0] d_hash, d_sp, d_dp;

    logic [AW-1:0] a_hash, a_sp, a_dp;
    logic [DW-1:0] d_left, d_right;
    logic          rd_en, d_vld, tsel, sys_state, sys_mode, res_we, busy, done;
    logic [1:0]    res_row;
    logic [0:0]    res_blk;
    logic [31:0]   perf_busy, perf_stall;

    logic [AW-1:0] x_hash, x_sp, x_dp;
    logic [DW-1:0] x_left, x_right;
    logic          x_rd_en, x_vld, x_tsel, x_sys_state, x_sys_mode, x_res_we, x_busy, x_done;
    logic [1:0]    x_res_row;
    logic [0:0]    x_res_blk;
    logic [31:0]   x_perf_busy, x_perf_stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mat_seq_ctrl #(.TILE(4), .N_LINES(4), .N_BLK(2), .DRAIN_CYC(8), .RD_LAT(1), .DATA_W(DW), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .cfg_l_base(l_base), .cfg_l_line_step(l_line), .cfg_l_beat_step(l_beat),
        .cfg_r_base(r_base), .cfg_r_blk_step(r_blk), .cfg_r_line_step(r_line), .cfg_r_beat_step(r_beat),
        .mem_rdy(mem_rdy), .bram_data_hash(d_hash), .bram_data_sp(d_sp), .bram_data_dp(d_dp),
        .addr_hash(a_hash), .addr_sp(a_sp), .addr_dp(a_dp), .rd_en(rd_en),
        .data_left(d_left), .data_right(d_right), .data_vld(d_vld),
        .transposition_select(tsel), .systolic_state(sys_state), .systolic_mode(sys_mode),
        .res_we(res_we), .res_row(res_row), .res_blk(res_blk), .busy(busy), .done(done),
        .perf_busy_cyc(perf_busy), .perf_stall_cyc(perf_stall)
    );

    mat_seq_ctrl #(.TILE(4), .N_LINES(4), .N_BLK(2), .DRAIN_CYC(8), .RD_LAT(3), .DATA_W(DW), .ADDR_W(AW)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .cfg_l_base(l_base), .cfg_l_line_step(l_line), .cfg_l_beat_step(l_beat),
        .cfg_r_base(r_base), .cfg_r_blk_step(r_blk), .cfg_r_line_step(r_line), .cfg_r_beat_step(r_beat),
        .mem_rdy(mem_rdy), .bram_data_hash(d_hash), .bram_data_sp(d_sp), .bram_data_dp(d_dp),
        .addr_hash(x_hash), .addr_sp(x_sp), .addr_dp(x_dp), .rd_en(x_rd_en),
        .data_left(x_left), .data_right(x_right), .data_vld(x_vld),
        .transposition_select(x_tsel), .systolic_state(x_sys_state), .systolic_mode(x_sys_mode),
        .res_we(x_res_we), .res_row(x_res_row), .res_blk(x_res_blk), .busy(x_busy), .done(x_done),
        .perf_busy_cyc(x_perf_busy), .perf_stall_cyc(x_perf_stall)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [AW-1:0] lb, ll, lbt, rb, rbk, rl, rbt);
        l_base = lb; l_line = ll; l_beat = lbt;
        r_base = rb; r_blk = rbk; r_line = rl; r_beat = rbt;
    endtask

    // Called at a negedge; returns at the negedge of cycle 0 (first cycle after the start edge).
    task automatic pulse_start(input logic [2:0] m);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of cycle c0; returns at the first idle negedge after done.
    task automatic wait_done(input int c0, output int dcyc);
        int c;
        c    = c0;
        dcyc = -1;
        while (c < 300) begin
            #1;
            if (done) begin
                dcyc = c;
                break;
            end
            @(negedge clk);
            c++;
        end
        if (dcyc < 0) $display("FAIL wait_done: timeout, got no done, want done");
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, dcyc, we_cnt, bad_hash, bad_data, nrd;
        logic prev_rd;

        rst = 1'b1; start = 1'b0; mode = '0; mem_rdy = 1'b1;
        set_cfg('0, '0, '0, '0, '0, '0, '0);
        d_hash = 64'h11; d_sp = 64'h22; d_dp = 64'h33;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_tsel", tsel, 1);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_addr_hash", a_hash, 0);
        check_eq("rst_vld", d_vld, 0);
        check_eq("rst_sys_mode", sys_mode, 0);
        check_eq("rst_perf_busy", perf_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic AS
        set_cfg(0, 64, 21504, 0, 43008, 32, 10752);
        pulse_start(3'd1);
        cyc = 0; we_cnt = 0; dcyc = -1;
        while (cyc < 200) begin
            #1;
            case (cyc)
                0: begin
                    check_eq("as_hash_c0", a_hash, 0);
                    check_eq("as_tsel_c0", tsel, 1);
                    check_eq("as_rd_en_c0", rd_en, 1);
                    check_eq("as_dp_c0", a_dp, 0);
                    check_eq("as_vld_c0", d_vld, 0);
                    check_eq("as_sys_mode", sys_mode, 1);
                    check_eq("lat3_rd_en_c0", x_rd_en, 1);
                end
                1: begin
                    check_eq("as_hash_c1", a_hash, 21504);
                    check_eq("as_tsel_c1", tsel, 0);
                    check_eq("as_vld_c1", d_vld, 1);
                    check_eq("as_left_c1", d_left, 64'h11);
                    check_eq("as_right_c1", d_right, 64'h22);
                end
                2: begin
                    check_eq("as_hash_c2", a_hash, 43008);
                    check_eq("lat3_vld_c2", x_vld, 0);
                    check_eq("lat3_left_c2", x_left, 0);
                end
                3: begin
                    check_eq("as_hash_c3", a_hash, 64512);
                    check_eq("lat3_vld_c3", x_vld, 1);
                    check_eq("lat3_left_c3", x_left, 64'h11);
                end
                4: begin
                    check_eq("as_hash_c4", a_hash, 64);
                    check_eq("as_sp_c4", a_sp, 32);
                end
                5:  check_eq("as_tsel_c5", tsel, 1);
                16: begin
                    check_eq("as_sys_state_drain", sys_state, 1);
                    check_eq("as_rd_en_drain", rd_en, 0);
                    check_eq("as_hash_drain", a_hash, 0);
                end
                18: check_eq("lat3_vld_c18", x_vld, 1);
                19: begin
                    check_eq("lat3_vld_c19", x_vld, 0);
                    check_eq("lat3_left_c19", x_left, 0);
                end
                24: begin
                    check_eq("as_res_we_c24", res_we, 1);
                    check_eq("as_res_row_c24", res_row, 0);
                    check_eq("as_sys_state_save", sys_state, 0);
                end
                25: check_eq("as_res_row_c25", res_row, 1);
                28: begin
                    check_eq("as_sp_blk1", a_sp, 43008);
                    check_eq("as_res_blk_blk1", res_blk, 1);
                end
                29: check_eq("as_sp_blk1_b1", a_sp, 53760);
                default: ;
            endcase
            if (res_we) we_cnt++;
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("as_done_cyc", dcyc, 56);
        check_eq("as_res_we_cnt", we_cnt, 8);
        @(negedge clk);
        #1;
        check_eq("as_busy_after", busy, 0);
        check_eq("as_done_after", done, 0);
        @(negedge clk);

        // SA and BS routing
        set_cfg(32'h1000, 32'h100, 32'h8, 32'h5000, 32'h800, 32'h40, 32'h2);
        pulse_start(3'd2);
        #1 check_eq("sa_sys_mode", sys_mode, 0);
        @(negedge clk);
        #1;
        check_eq("sa_sp", a_sp, 32'h1008);
        check_eq("sa_hash", a_hash, 32'h5002);
        check_eq("sa_dp", a_dp, 0);
        check_eq("sa_left", d_left, 64'h22);
        check_eq("sa_right", d_right, 64'h11);
        wait_done(1, dcyc);
        check_eq("sa_done_cyc", dcyc, 56);

        pulse_start(3'd4);
        @(negedge clk);
        #1;
        check_eq("bs_dp", a_dp, 32'h1008);
        check_eq("bs_sp", a_sp, 32'h5002);
        check_eq("bs_hash", a_hash, 0);
        check_eq("bs_left", d_left, 64'h33);
        check_eq("bs_right", d_right, 64'h22);
        wait_done(1, dcyc);
        check_eq("bs_done_cyc", dcyc, 56);

        // SB routing with A5/3C data
        d_hash = 64'h77; d_sp = 64'hA5; d_dp = 64'h3C;
        set_cfg(32'h100, 32'h10, 32'h1, 32'h2000, 32'h400, 32'h40, 32'h4);
        pulse_start(3'd3);
        cyc = 0; dcyc = -1; bad_hash = 0; bad_data = 0; nrd = 0; prev_rd = 1'b0;
        while (cyc < 200) begin
            #1;
            if (a_hash != 0) bad_hash++;
            if (prev_rd) begin
                nrd++;
                if (!(d_vld && d_left == 64'hA5 && d_right == 64'h3C)) bad_data++;
            end
            prev_rd = rd_en;
            if (cyc == 0)  check_eq("sb_sys_mode", sys_mode, 1);
            if (cyc == 5)  begin check_eq("sb_sp_c5", a_sp, 32'h111); check_eq("sb_dp_c5", a_dp, 32'h2044); end
            if (cyc == 33) begin check_eq("sb_sp_c33", a_sp, 32'h111); check_eq("sb_dp_c33", a_dp, 32'h2444); end
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("sb_hash_nonzero_cnt", bad_hash, 0);
        check_eq("sb_data_bad_cnt", bad_data, 0);
        check_eq("sb_rd_cnt", nrd, 32);
        check_eq("sb_done_cyc", dcyc, 56);
        @(negedge clk);

        // Stall of 3 cycles at line 1, beat 2
        d_hash = 64'h11; d_sp = 64'h22; d_dp = 64'h33;
        set_cfg(0, 64, 21504, 0, 43008, 32, 10752);
        pulse_start(3'd1);
        cyc = 0; dcyc = -1;
        while (cyc < 200) begin
            mem_rdy = !(cyc >= 6 && cyc <= 8);
            #1;
            case (cyc)
                5:  check_eq("st_hash_c5", a_hash, 21568);
                6:  begin check_eq("st_hash_c6", a_hash, 43072); check_eq("st_rd_en_c6", rd_en, 0); end
                7:  begin check_eq("st_hash_c7", a_hash, 43072); check_eq("st_vld_c7", d_vld, 0); end
                8:  check_eq("st_hash_c8", a_hash, 43072);
                9:  begin check_eq("st_hash_c9", a_hash, 43072); check_eq("st_rd_en_c9", rd_en, 1); end
                10: begin check_eq("st_hash_c10", a_hash, 64576); check_eq("st_vld_c10", d_vld, 1); end
                default: ;
            endcase
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        mem_rdy = 1'b1;
        check_eq("st_done_cyc", dcyc, 59);
        @(negedge clk);
        #1;
`ifdef MAT_SEQ_PERF_EN
        check_eq("st_perf_busy", perf_busy, 60);
        check_eq("st_perf_stall", perf_stall, 3);
`else
        check_eq("st_perf_busy", perf_busy, 0);
        check_eq("st_perf_stall", perf_stall, 0);
`endif
        @(negedge clk);

        // Illegal mode
        pulse_start(3'd5);
        dcyc = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (busy || done) dcyc++;
            @(negedge clk);
        end
        check_eq("ill_busy_or_done_cnt", dcyc, 0);

        // Start pulsed during DRAIN is ignored
        pulse_start(3'd1);
        repeat (18) @(negedge clk);
        mode  = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(19, dcyc);
        check_eq("drn_start_done_cyc", dcyc, 56);
        #1 check_eq("drn_start_sys_mode", sys_mode, 1);
        @(negedge clk);

        // Reset at cycle 20
        pulse_start(3'd1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_tsel", tsel, 1);
        check_eq("mrst_sys_state", sys_state, 0);
        check_eq("mrst_sys_mode", sys_mode, 0);
        check_eq("mrst_rd_en", rd_en, 0);
        check_eq("mrst_perf_busy", perf_busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset during LOAD discards in-flight reads
        pulse_start(3'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("lrst_vld", d_vld, 0);
        check_eq("lrst_left", d_left, 0);
        check_eq("lrst_lat3_vld", x_vld, 0);
        rst = 1'b0;
        @(negedge clk);
        #1 check_eq("lrst_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
